// File: rtl/fd_circle_fetch_if.sv
// Signal bundle between the FAST scheduler/SRAM side and fd_circle_fetch.
// The master side requests evaluations and returns SRAM data; the slave side is the sequencer.
interface fd_circle_fetch_if;
    logic        start;
    logic [6:0]  refRow;
    logic [7:0]  refCol;
    logic [7:0]  threshold;
    logic [14:0] refAddr;
    logic [4:0]  adjNumber;
    logic [7:0]  sramData;
    logic        busy;
    logic        done;
    logic        isCorner;
    logic [4:0]  brightRun;
    logic [4:0]  darkRun;

    modport master (
        output start, refRow, refCol, threshold, sramData,
        input  refAddr, adjNumber, busy, done, isCorner, brightRun, darkRun
    );

    modport slave (
        input  start, refRow, refCol, threshold, sramData,
        output refAddr, adjNumber, busy, done, isCorner, brightRun, darkRun
    );
endinterface

// File: rtl/fd_circle_fetch.sv
// FAST read-side sequencer: walks the center and 16 circle points of one candidate,
// classifies the returned intensities and runs the contiguous-arc corner test.
module fd_circle_fetch #(
    parameter int RD_LAT  = 1,
    parameter int ARC     = 9,
    parameter int COLUMNS = 180,
    parameter int ROWS    = 120
) (
    input  logic             clk,
    input  logic             rst,
    fd_circle_fetch_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EVAL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             adj_q, adj_d;
    logic [14:0]            addr_q, addr_d;
    logic [7:0]             thr_q, thr_d;
    logic [7:0]             center_q, center_d;
    logic [15:0]            bright_q, bright_d;
    logic [15:0]            dark_q, dark_d;
    logic [RD_LAT-1:0][4:0] tag_q, tag_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   corner_q, corner_d;
    logic [4:0]             brun_q, brun_d;
    logic [4:0]             drun_q, drun_d;

    logic       border;
    logic [4:0] tag_out;
    logic [8:0] p9, hi9, lo9;
    logic       is_bright, is_dark;
    logic [4:0] brun_eval, drun_eval;

    // Longest circular run: scanning the mask twice catches runs that wrap 16 -> 1;
    // the saturating counter makes an all-ones mask report exactly 16.
    function automatic logic [4:0] circ_run(input logic [15:0] m);
        logic [31:0] dbl;
        logic [4:0]  run;
        logic [4:0]  best;
        dbl  = {m, m};
        run  = 5'd0;
        best = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (dbl[i]) begin
                if (run != 5'd16) run = run + 5'd1;
            end else begin
                run = 5'd0;
            end
            if (run > best) best = run;
        end
        return best;
    endfunction

    assign border = (int'(bus.refRow) < 3) || (int'(bus.refRow) > ROWS - 4) ||
                    (int'(bus.refCol) < 3) || (int'(bus.refCol) > COLUMNS - 4);

    assign tag_out   = tag_q[RD_LAT-1];
    assign p9        = {1'b0, bus.sramData};
    assign hi9       = {1'b0, center_q} + {1'b0, thr_q};
    assign lo9       = {1'b0, center_q} - {1'b0, thr_q};
    assign is_bright = p9 > hi9;
    assign is_dark   = (center_q >= thr_q) && (p9 < lo9);
    assign brun_eval = circ_run(bright_q);
    assign drun_eval = circ_run(dark_q);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d  = state_q;
        adj_d    = adj_q;
        addr_d   = addr_q;
        thr_d    = thr_q;
        center_d = center_q;
        bright_d = bright_q;
        dark_d   = dark_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        corner_d = corner_q;
        brun_d   = brun_q;
        drun_d   = drun_q;

        tag_d[0] = adj_q;
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

        if (tag_out == 5'd17) begin
            center_d = bus.sramData;
        end else if (tag_out != 5'd0) begin
            bright_d[4'(tag_out - 5'd1)] = is_bright;
            dark_d[4'(tag_out - 5'd1)]   = is_dark;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    thr_d  = bus.threshold;
                    addr_d = 15'(bus.refRow) * 15'(COLUMNS) + 15'(bus.refCol);
                    busy_d = 1'b1;
                    if (border) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        corner_d = 1'b0;
                        brun_d   = 5'd0;
                        drun_d   = 5'd0;
                    end else begin
                        state_d = ISSUE;
                        adj_d   = 5'd17;
                    end
                end
            end
            ISSUE: begin
                if (adj_q == 5'd17) begin
                    adj_d = 5'd1;
                end else if (adj_q == 5'd16) begin
                    adj_d   = 5'd0;
                    cnt_d   = 3'(RD_LAT - 1);
                    state_d = DRAIN;
                end else begin
                    adj_d = adj_q + 5'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == 3'd0) state_d = EVAL;
                else               cnt_d   = cnt_q - 3'd1;
            end
            EVAL: begin
                brun_d   = brun_eval;
                drun_d   = drun_eval;
                corner_d = (int'(brun_eval) >= ARC) || (int'(drun_eval) >= ARC);
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag pipe must clear on reset so in-flight SRAM data is never captured.
            state_q  <= IDLE;
            adj_q    <= '0;
            addr_q   <= '0;
            thr_q    <= '0;
            center_q <= '0;
            bright_q <= '0;
            dark_q   <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            corner_q <= 1'b0;
            brun_q   <= '0;
            drun_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            state_q  <= state_d;
            adj_q    <= adj_d;
            addr_q   <= addr_d;
            thr_q    <= thr_d;
            center_q <= center_d;
            bright_q <= bright_d;
            dark_q   <= dark_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            corner_q <= corner_d;
            brun_q   <= brun_d;
            drun_q   <= drun_d;
        end
    end

    assign bus.refAddr   = addr_q;
    assign bus.adjNumber = adj_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.isCorner  = corner_q;
    assign bus.brightRun = brun_q;
    assign bus.darkRun   = drun_q;
endmodule

// File: tb/tb_fd_circle_fetch.sv
// Scoreboard bench for fd_circle_fetch: RD_LAT=1 instance for the main cases,
// plus an RD_LAT=3 instance for latency and capture alignment.
module tb_fd_circle_fetch;
    localparam int COLS = 180;
    localparam int ROWS = 120;
    localparam int ARC  = 9;

    typedef struct {
        logic corner;
        int   br;
        int   dk;
        int   addr;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fd_circle_fetch_if bus0 ();
    fd_circle_fetch_if bus1 ();

    fd_circle_fetch #(.RD_LAT(1), .ARC(ARC), .COLUMNS(COLS), .ROWS(ROWS)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    fd_circle_fetch #(.RD_LAT(3), .ARC(ARC), .COLUMNS(COLS), .ROWS(ROWS)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Point-indexed SRAM model: index 17 is the center, 1..16 the ring.
    logic [7:0] pix [0:17];
    logic [4:0] pipe0 = 5'd0;
    logic [4:0] pipe1 [0:2] = '{5'd0, 5'd0, 5'd0};
    int         cyc = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pipe0    <= bus0.adjNumber;
        pipe1[0] <= bus1.adjNumber;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign bus0.sramData = pix[pipe0];
    assign bus1.sramData = pix[pipe1[2]];

    exp_t exp_q[$];
    exp_t mon_e;
    int   acc_cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic last_corner = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int longest(input logic [15:0] m);
        int best;
        int k;
        best = 0;
        for (int s = 0; s < 16; s++) begin
            k = 0;
            while (k < 16 && m[(s + k) % 16]) k++;
            if (k > best) best = k;
        end
        return best;
    endfunction

    function automatic exp_t model(input int row, input int col, input int t, input int lat);
        exp_t        r;
        logic [15:0] bm;
        logic [15:0] dm;
        int          c;
        int          p;
        c      = int'(pix[17]);
        r.addr = row * COLS + col;
        if (row < 3 || row > ROWS - 4 || col < 3 || col > COLS - 4) begin
            r.corner = 1'b0; r.br = 0; r.dk = 0; r.lat = 1;
            return r;
        end
        for (int n = 1; n <= 16; n++) begin
            p         = int'(pix[n]);
            bm[n - 1] = p > c + t;
            dm[n - 1] = (c >= t) && (p < c - t);
        end
        r.br     = longest(bm);
        r.dk     = longest(dm);
        r.corner = (r.br >= ARC) || (r.dk >= ARC);
        r.lat    = 19 + lat;
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus0.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("isCorner",  bus0.isCorner,  mon_e.corner);
                check("brightRun", bus0.brightRun, mon_e.br);
                check("darkRun",   bus0.darkRun,   mon_e.dk);
                check("refAddr",   bus0.refAddr,   mon_e.addr);
                check("latency",   cyc - acc_cyc,  mon_e.lat);
                last_corner = mon_e.corner;
            end
        end
    end

    task automatic set_ring(input int c, input int v);
        pix[0]  = 8'd0;
        pix[17] = 8'(c);
        for (int n = 1; n <= 16; n++) pix[n] = 8'(v);
    endtask

    // pulse: re-assert start while busy; abort_adj: assert rst when adjNumber hits it.
    task automatic run_case(input int row, input int col, input int t,
                            input bit pulse, input int abort_adj);
        exp_t e;
        int   exp_adj;
        bit   seen;
        seen = 1'b0;
        e    = model(row, col, t, 1);
        if (abort_adj == 0) exp_q.push_back(e);
        @(negedge clk);
        bus0.start     = 1'b1;
        bus0.refRow    = 7'(row);
        bus0.refCol    = 8'(col);
        bus0.threshold = 8'(t);
        acc_cyc        = cyc;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus0.start     = 1'b0;
                bus0.refRow    = 7'd60;
                bus0.refCol    = 8'd90;
                bus0.threshold = 8'd255;
                check("busy_c1", bus0.busy, 1);
                if (e.lat > 1) check("held_isCorner", bus0.isCorner, last_corner);
            end
            if (pulse && j == 5) bus0.start = 1'b1;
            if (pulse && j == 6) bus0.start = 1'b0;
            if (e.lat == 1)    exp_adj = 0;
            else if (j == 1)   exp_adj = 17;
            else if (j <= 17)  exp_adj = j - 1;
            else               exp_adj = 0;
            check("adjNumber", bus0.adjNumber, exp_adj);
            if (abort_adj != 0 && int'(bus0.adjNumber) == abort_adj) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_adj",  bus0.adjNumber, 0);
                check("rst_busy", bus0.busy, 0);
                check("rst_done", bus0.done, 0);
                rst         = 1'b0;
                last_corner = 1'b0;
                repeat (30) @(negedge clk);
                check("rst_idle_busy", bus0.busy, 0);
                return;
            end
            if (bus0.done === 1'b1) begin
                seen = 1'b1;
                check("busy_done", bus0.busy, 1);
                break;
            end
        end
        if (!seen) begin
            check("timeout", 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
        check("busy_after", bus0.busy, 0);
        check("done_after", bus0.done, 0);
    endtask

    task automatic run_lat3(input logic corner, input int br, input int dk);
        int  acc1;
        bit  seen;
        seen = 1'b0;
        @(negedge clk);
        bus1.start     = 1'b1;
        bus1.refRow    = 7'd10;
        bus1.refCol    = 8'd10;
        bus1.threshold = 8'd20;
        acc1           = cyc;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int j = 2; j <= 60 && !seen; j++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) begin
                seen = 1'b1;
                check("lat3_latency",   cyc - acc1, 22);
                check("lat3_isCorner",  bus1.isCorner, corner);
                check("lat3_brightRun", bus1.brightRun, br);
                check("lat3_darkRun",   bus1.darkRun, dk);
                check("lat3_refAddr",   bus1.refAddr, 1810);
            end
        end
        if (!seen) check("lat3_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus0.start     = 1'b0;
        bus0.refRow    = 7'd0;
        bus0.refCol    = 8'd0;
        bus0.threshold = 8'd0;
        bus1.start     = 1'b0;
        bus1.refRow    = 7'd0;
        bus1.refCol    = 8'd0;
        bus1.threshold = 8'd0;
        set_ring(100, 100);
        repeat (3) @(negedge clk);
        check("reset_adj",    bus0.adjNumber, 0);
        check("reset_addr",   bus0.refAddr, 0);
        check("reset_busy",   bus0.busy, 0);
        check("reset_done",   bus0.done, 0);
        check("reset_corner", bus0.isCorner, 0);
        check("reset_bright", bus0.brightRun, 0);
        check("reset_dark",   bus0.darkRun, 0);
        check("reset_busy1",  bus1.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        set_ring(100, 100);  run_case(10, 10, 20, 1'b0, 0);
        set_ring(10, 200);   run_case(10, 10, 20, 1'b0, 0);

        set_ring(100, 100);
        for (int n = 13; n <= 16; n++) pix[n] = 8'd50;
        for (int n = 1; n <= 5; n++)   pix[n] = 8'd50;
        run_case(20, 30, 10, 1'b0, 0);
        pix[5] = 8'd100;
        run_case(20, 30, 10, 1'b0, 0);

        set_ring(100, 120);  run_case(40, 40, 20, 1'b0, 0);
        set_ring(100, 121);  run_case(40, 40, 20, 1'b0, 0);
        set_ring(5, 0);      run_case(40, 40, 20, 1'b0, 0);
        set_ring(100, 79);   run_case(116, 176, 20, 1'b0, 0);

        run_case(2, 50, 20, 1'b0, 0);
        run_case(10, 177, 20, 1'b0, 0);

        set_ring(10, 200);   run_case(50, 90, 20, 1'b1, 0);
        set_ring(100, 100);  run_case(10, 10, 20, 1'b0, 5);
        set_ring(100, 50);   run_case(60, 100, 20, 1'b0, 0);

        set_ring(100, 100);  run_lat3(1'b0, 0, 0);
        set_ring(10, 200);   run_lat3(1'b1, 16, 0);
        set_ring(100, 100);
        for (int n = 13; n <= 16; n++) pix[n] = 8'd50;
        for (int n = 1; n <= 5; n++)   pix[n] = 8'd50;
        run_lat3(1'b1, 0, 9);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
